// File: rtl/phy_stim_gen_chk.sv
// PHY transmit-path stimulus generator (inc / gapped-inc / dec patterns over LANES lanes)
// plus a cycle-by-cycle checker comparing behavioural and synthesized output streams.

module phy_stim_lane #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANE  = 0
) (
  input  logic             clk_f,
  input  logic             reset_L,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] beat,
  output logic [WIDTH-1:0] data
);
  logic [WIDTH-1:0] data_d, data_q;
  logic [WIDTH-1:0] base;

  assign base = seed + WIDTH'(LANE);

  always_comb begin
    data_d = data_q;
    if (clear)     data_d = '0;
    else if (load) data_d = dec ? (base - beat) : (base + beat);
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data = data_q;
endmodule

module phy_stim_gen_chk #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk_f,
  input  logic                   reset_L,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [7:0]             burst_len,
  input  logic [WIDTH-1:0]       seed,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   idle,
  output logic                   done,
  input  logic [WIDTH-1:0]       data_cond,
  input  logic                   valid_cond,
  input  logic [WIDTH-1:0]       data_synt,
  input  logic                   valid_synt,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       match_count,
  output logic [CNT_W-1:0]       err_count
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0] M_GAP = 2'b01;
  localparam logic [1:0] M_DEC = 2'b10;

  state_t           st_d, st_q;
  logic [1:0]       mode_d, mode_q;
  logic [WIDTH-1:0] seed_d, seed_q;
  logic [7:0]       len_d, len_q;
  logic [7:0]       n_d, n_q;
  logic             gap_d, gap_q;
  logic             valid_d, valid_q;
  logic             idle_d, idle_q;
  logic             done_d, done_q;
  logic             mis_d, mis_q;
  logic [CNT_W-1:0] match_d, match_q;
  logic [CNT_W-1:0] err_d, err_q;

  logic accept, issue, lane_clr, cmp, hit;

  // Generator FSM. Status outputs lag the state by one edge so that idle/done
  // line up with the registered beat on data_out.
  always_comb begin
    st_d     = st_q;
    mode_d   = mode_q;
    seed_d   = seed_q;
    len_d    = len_q;
    n_d      = n_q;
    gap_d    = gap_q;
    accept   = 1'b0;
    issue    = 1'b0;
    case (st_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept = 1'b1;
          mode_d = (mode == 2'b11) ? 2'b00 : mode;
          seed_d = seed;
          len_d  = burst_len;
          n_d    = '0;
          gap_d  = 1'b0;
          st_d   = (burst_len == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        issue = !gap_q;
        gap_d = (mode_q == M_GAP) ? !gap_q : 1'b0;
        if (issue) begin
          n_d = n_q + 8'd1;
          if (n_q == len_q - 8'd1) st_d = S_DONE;
        end
      end
      default: st_d = S_IDLE;
    endcase
    lane_clr = (st_q != S_RUN);
    valid_d  = issue;
    idle_d   = (st_q != S_RUN);
    done_d   = (st_q == S_DONE);
  end

  // Checker: a start acceptance clears the counters and swallows that cycle's compare.
  always_comb begin
    cmp     = valid_cond | valid_synt;
    hit     = valid_cond & valid_synt & (data_cond == data_synt);
    match_d = match_q;
    err_d   = err_q;
    mis_d   = 1'b0;
    if (accept) begin
      match_d = '0;
      err_d   = '0;
    end else if (cmp) begin
      if (hit) begin
        if (match_q != {CNT_W{1'b1}}) match_d = match_q + CNT_W'(1);
      end else begin
        mis_d = 1'b1;
        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      st_q    <= S_IDLE;
      mode_q  <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      n_q     <= '0;
      gap_q   <= 1'b0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      match_q <= '0;
      err_q   <= '0;
    end else begin
      st_q    <= st_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      n_q     <= n_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  logic [LANES-1:0][WIDTH-1:0] lane_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    phy_stim_lane #(.WIDTH(WIDTH), .LANE(k)) u_lane (
      .clk_f   (clk_f),
      .reset_L (reset_L),
      .clear   (lane_clr),
      .load    (issue),
      .dec     (mode_q == M_DEC),
      .seed    (seed_q),
      .beat    (WIDTH'(n_q)),
      .data    (lane_data[k])
    );
  end

  assign data_out    = lane_data;
  assign valid_out   = {LANES{valid_q}};
  assign idle        = idle_q;
  assign done        = done_q;
  assign mismatch    = mis_q;
  assign match_count = match_q;
  assign err_count   = err_q;
endmodule
